// File: rtl/demux8_reg.sv
//------------------------------------------------------------------------------
// demux8_reg
//
// Registered 1-to-8 demultiplexer. It is the distribution side of the 8-way
// ALU result mux: each incoming word is steered to one of eight sink channels
// chosen by in_sel. Every channel has its own one-entry output register and
// its own valid/ready handshake, so a stalled sink only blocks words that are
// addressed to it.
//
// Parameters:
//   WIDTH  - data width of the input word and of each channel
//   CNT_W  - width of the accepted-transfer counter (wraps modulo 2^CNT_W)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   input word present
//   in_ready   out  the addressed channel (or all channels for broadcast)
//                   can take the word this cycle
//   in_data    in   input word
//   in_sel     in   destination channel 0..7
//   in_bcast   in   (DEMUX8_BCAST_EN only) write the word to all channels
//   out_valid  out  bit i = channel i holds a word
//   out_ready  in   bit i = sink i consumes this cycle
//   out_data   out  channel i data at bits [i*WIDTH +: WIDTH]
//   xfer_cnt   out  number of accepted input words
//
// Optional feature macro: DEMUX8_BCAST_EN
//   When defined, the in_bcast port is added and a broadcast write loads all
//   eight channels at once when every channel is free.
//------------------------------------------------------------------------------
module demux8_reg #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [2:0]           in_sel,
`ifdef DEMUX8_BCAST_EN
   input  logic                 in_bcast,
`endif
   output logic [7:0]           out_valid,
   input  logic [7:0]           out_ready,
   output logic [8*WIDTH-1:0]   out_data,
   output logic [CNT_W-1:0]     xfer_cnt
);

   logic [7:0]       chFree;
   logic [7:0]       writeMask;
   logic             readyInt;
   logic             accept;
   logic [WIDTH-1:0] chData [8];

   // A channel can take a new word when it is empty or when its current word
   // leaves this same cycle, which lets a draining channel be refilled without
   // a bubble. The ready decision never looks at in_valid, so the producer sees
   // a stable ready regardless of what it is offering. writeMask marks which
   // channel registers load at the next edge when the word is accepted.
   always_comb begin
      chFree    = ~out_valid | out_ready;
      readyInt  = chFree[in_sel];
      writeMask = 8'b0000_0001 << in_sel;
`ifdef DEMUX8_BCAST_EN
      if (in_bcast) begin
         readyInt  = &chFree;
         writeMask = 8'hFF;
      end
`endif
      accept = in_valid && readyInt;
   end

   assign in_ready = readyInt;

   // Channel registers. A write to a channel takes priority over its drain so
   // that a simultaneous drain and refill keeps valid high and swaps in the new
   // word. A channel that only drains clears its valid but keeps its stale data.
   // Reset discards everything, including a word being accepted the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            chData[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (accept && writeMask[i]) begin
               out_valid[i] <= 1'b1;
               chData[i]    <= in_data;
            end else if (out_ready[i]) begin
               out_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Accepted-word counter; a broadcast counts as one transfer. It wraps
   // naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_cnt <= '0;
      end else if (accept) begin
         xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
   end

   // Flatten the per-channel registers onto the packed output bus.
   for (genvar g = 0; g < 8; g++) begin : gOut
      assign out_data[g*WIDTH +: WIDTH] = chData[g];
   end

endmodule

// File: tb/tb_demux8_reg.sv
//------------------------------------------------------------------------------
// tb_demux8_reg
//
// Self-checking bench for demux8_reg. Directed stimulus pushes the word each
// channel should deliver into a per-channel expected queue; an independent
// monitor pops and compares whenever a channel completes a valid/ready
// handshake. Direct checks cover out_valid, xfer_cnt, in_ready and held data.
//------------------------------------------------------------------------------
module tb_demux8_reg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic [2:0]           in_sel;
`ifdef DEMUX8_BCAST_EN
   logic                 in_bcast;
`endif
   logic [7:0]           out_valid;
   logic [7:0]           out_ready;
   logic [8*WIDTH-1:0]   out_data;
   logic [CNT_W-1:0]     xfer_cnt;

   logic [WIDTH-1:0]     expQ [8][$];
   int                   vectors = 0;
   int                   miscompares = 0;

   demux8_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
`ifdef DEMUX8_BCAST_EN
      .in_bcast  (in_bcast),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .xfer_cnt  (xfer_cnt)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Monitor: a handshake seen at the falling edge completes at the next rising
   // edge, so the word on the channel must be the oldest one expected there.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            if (out_valid[i] && out_ready[i]) begin
               logic [WIDTH-1:0] expWord;
               vectors++;
               if (expQ[i].size() == 0) begin
                  miscompares++;
                  $display("[TB] FAIL drain ch%0d: got %h, want no word", i, out_data[i*WIDTH +: WIDTH]);
               end else begin
                  expWord = expQ[i].pop_front();
                  if (out_data[i*WIDTH +: WIDTH] !== expWord) begin
                     miscompares++;
                     $display("[TB] FAIL drain ch%0d: got %h, want %h", i, out_data[i*WIDTH +: WIDTH], expWord);
                  end
               end
            end
         end
      end
   end

   // Drive one cycle of stimulus, check in_ready mid-cycle, record the word
   // as expected output when it should be accepted, and return just after
   // the rising edge.
   task automatic applyStimulus(input logic v, input logic [2:0] sel, input logic [WIDTH-1:0] d,
                                input logic [7:0] rdy, input logic bc, input string name,
                                input logic expReady);
      in_valid  = v;
      in_sel    = sel;
      in_data   = d;
      out_ready = rdy;
`ifdef DEMUX8_BCAST_EN
      in_bcast  = bc;
`endif
      @(negedge clk);
      vectors++;
      if (in_ready !== expReady) begin
         miscompares++;
         $display("[TB] FAIL %s in_ready: got %b, want %b", name, in_ready, expReady);
      end
      if (v && expReady) begin
         if (bc) begin
            for (int i = 0; i < 8; i++) expQ[i].push_back(d);
         end else begin
            expQ[sel].push_back(d);
         end
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 8'h00;
`ifdef DEMUX8_BCAST_EN
      in_bcast  = 1'b0;
`endif
   endtask

   // Hold reset for n cycles while optionally offering a word that must be lost.
   task automatic doReset(input int n, input logic v, input logic [7:0] rdy);
      rst       = 1'b1;
      in_valid  = v;
      in_sel    = 3'd0;
      in_data   = 32'h0000_0BAD;
      out_ready = rdy;
      repeat (n) @(posedge clk);
      #1;
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 8'h00;
      for (int i = 0; i < 8; i++) expQ[i].delete();
   endtask

   // Compare the valid vector and transfer count against hand-computed values.
   task automatic checkOutput(input string name, input logic [7:0] expValid, input logic [CNT_W-1:0] expCnt);
      vectors++;
      if (out_valid !== expValid) begin
         miscompares++;
         $display("[TB] FAIL %s out_valid: got %h, want %h", name, out_valid, expValid);
      end
      vectors++;
      if (xfer_cnt !== expCnt) begin
         miscompares++;
         $display("[TB] FAIL %s xfer_cnt: got %h, want %h", name, xfer_cnt, expCnt);
      end
   endtask

   // Compare the data held in one channel.
   task automatic checkData(input string name, input int ch, input logic [WIDTH-1:0] expWord);
      vectors++;
      if (out_data[ch*WIDTH +: WIDTH] !== expWord) begin
         miscompares++;
         $display("[TB] FAIL %s ch%0d data: got %h, want %h", name, ch, out_data[ch*WIDTH +: WIDTH], expWord);
      end
   endtask

   initial begin
      in_valid  = 1'b0;
      in_sel    = 3'd0;
      in_data   = '0;
      out_ready = 8'h00;
`ifdef DEMUX8_BCAST_EN
      in_bcast  = 1'b0;
`endif
      @(posedge clk);
      #1;
      doReset(2, 1'b0, 8'h00);

      // Reset state.
      checkOutput("reset", 8'h00, 16'h0000);
      vectors++;
      if (out_data !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset out_data: got %h, want 0", out_data);
      end

      // Single write to channel 3 with the sink stalled.
      applyStimulus(1'b1, 3'd3, 32'hDEAD_BEEF, 8'h00, 1'b0, "single", 1'b1);
      checkOutput("single", 8'h08, 16'h0001);
      checkData("single", 3, 32'hDEAD_BEEF);

      // Backpressure on channel 3, then an unrelated channel still accepts.
      applyStimulus(1'b1, 3'd3, 32'h1234_5678, 8'h00, 1'b0, "bpFull", 1'b0);
      checkOutput("bpFull", 8'h08, 16'h0001);
      checkData("bpFull", 3, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 3'd5, 32'h1234_5678, 8'h00, 1'b0, "bpOther", 1'b1);
      checkOutput("bpOther", 8'h28, 16'h0002);
      checkData("bpOther", 5, 32'h1234_5678);
      checkData("bpOther", 3, 32'hDEAD_BEEF);

      // Drain and refill channel 2 in the same cycle.
      applyStimulus(1'b1, 3'd2, 32'h0000_000A, 8'h00, 1'b0, "fillA", 1'b1);
      checkOutput("fillA", 8'h2C, 16'h0003);
      applyStimulus(1'b1, 3'd2, 32'h0000_000B, 8'h04, 1'b0, "refillB", 1'b1);
      checkOutput("refillB", 8'h2C, 16'h0004);
      checkData("refillB", 2, 32'h0000_000B);
      checkData("refillB", 3, 32'hDEAD_BEEF);

      // Empty everything, then sweep all eight channels back to back.
      applyStimulus(1'b0, 3'd0, 32'h0, 8'hFF, 1'b0, "drain1", 1'b1);
      checkOutput("drain1", 8'h00, 16'h0004);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 3'(i), 32'h100 + 32'(i), 8'h00, 1'b0, "sweep", 1'b1);
      end
      checkOutput("sweep", 8'hFF, 16'h000C);
      for (int i = 0; i < 8; i++) checkData("sweep", i, 32'h100 + 32'(i));
      applyStimulus(1'b0, 3'd0, 32'h0, 8'hFF, 1'b0, "drainAll", 1'b1);
      checkOutput("drainAll", 8'h00, 16'h000C);

      // Counter wrap: 65535 accepts on channel 0 with continuous drain/refill.
      doReset(1, 1'b0, 8'h00);
      checkOutput("reset2", 8'h00, 16'h0000);
      for (int k = 0; k < 65535; k++) begin
         applyStimulus(1'b1, 3'd0, 32'(k), 8'h01, 1'b0, "wrapLoop", 1'b1);
      end
      checkOutput("preWrap", 8'h01, 16'hFFFF);
      checkData("preWrap", 0, 32'h0000_FFFE);
      applyStimulus(1'b1, 3'd0, 32'hCAFE_0001, 8'h01, 1'b0, "wrap", 1'b1);
      checkOutput("wrap", 8'h01, 16'h0000);
      applyStimulus(1'b0, 3'd0, 32'h0, 8'hFF, 1'b0, "drain2", 1'b1);
      checkOutput("drain2", 8'h00, 16'h0000);

      // Fill all channels, then reset while a word is offered and sinks ready.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 3'(i), 32'h200 + 32'(i), 8'h00, 1'b0, "fill2", 1'b1);
      end
      checkOutput("fill2", 8'hFF, 16'h0008);
      doReset(1, 1'b1, 8'hFF);
      checkOutput("midReset", 8'h00, 16'h0000);
      vectors++;
      if (out_data !== '0) begin
         miscompares++;
         $display("[TB] FAIL midReset out_data: got %h, want 0", out_data);
      end

`ifdef DEMUX8_BCAST_EN
      // Broadcast into empty channels, then a blocked broadcast with ch6 full.
      applyStimulus(1'b1, 3'd2, 32'h55AA_55AA, 8'h00, 1'b1, "bcast", 1'b1);
      checkOutput("bcast", 8'hFF, 16'h0001);
      for (int i = 0; i < 8; i++) checkData("bcast", i, 32'h55AA_55AA);
      applyStimulus(1'b0, 3'd0, 32'h0, 8'hBF, 1'b0, "drainBut6", 1'b1);
      checkOutput("drainBut6", 8'h40, 16'h0001);
      applyStimulus(1'b1, 3'd0, 32'h0F0F_0F0F, 8'h00, 1'b1, "bcastBlocked", 1'b0);
      checkOutput("bcastBlocked", 8'h40, 16'h0001);
      for (int i = 0; i < 8; i++) checkData("bcastBlocked", i, 32'h55AA_55AA);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/demux8_reg.md
Name: demux8_reg

Overview:
- Registered 1-to-8 demultiplexer. It takes one WIDTH-bit result stream and routes each word to one of eight sink channels, chosen by a 3-bit select.
- It is the distribution-side counterpart of the 8-way operand/result mux in ALU_RV32. It fans ALU/writeback results out to eight consumers.
- Every channel has an independent one-entry output register with a valid/ready handshake. A stalled sink blocks only traffic addressed to it.

Parameters:
- WIDTH, 32, data width of the input word and of each channel.
- CNT_W, 16, width of the accepted-transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  demux can accept the word on in_sel this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  3  destination channel, 0..7.
- out_valid  output  8  bit i = channel i holds a word.
- out_ready  input  8  bit i = sink i consumes this cycle.
- out_data  output  8*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- xfer_cnt  output  CNT_W  count of accepted input words.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=8'h00, out_data all zero, xfer_cnt=0. in_ready is combinational and evaluates to 1 after reset, because every channel is empty.
- Channel i free: ch_free[i] = !out_valid[i] || out_ready[i]. Pass-through while draining is allowed.
- in_ready = ch_free[in_sel]. It is combinational from in_sel, out_valid and out_ready, and does not depend on in_valid.
- Accept: acc = in_valid && in_ready.
- On acc, at the next edge: out_data[in_sel] <= in_data, out_valid[in_sel] <= 1, xfer_cnt <= xfer_cnt + 1.
- Latency: a word accepted in cycle N is visible on out_data/out_valid in cycle N+1.
- Channel drain: out_valid[i] && out_ready[i] with no new write to i at the same edge -> out_valid[i] <= 0. out_data[i] holds its last value and is don't-care semantically.
- Simultaneous drain and refill of the same channel: out_valid[i] stays 1 and out_data[i] takes the new word. No bubble, no loss.
- Full channel: out_valid[in_sel]=1 and out_ready[in_sel]=0 -> in_ready=0. The word is not accepted and the producer must hold in_valid, in_data and in_sel stable.
- Other channels: writes to one channel never modify out_valid or out_data of any other channel. All eight channels drain independently in the same cycle.
- in_sel covers the full range 0..7. There is no invalid encoding.
- xfer_cnt wraps modulo 2^CNT_W (0xFFFF + 1 -> 0x0000). It increments by exactly 1 per accepted word, including broadcast.
- Reset mid-operation: all buffered words are discarded, with no drain handshake. rst overrides any simultaneous acc or drain.
- out_valid/out_data sink semantics: once asserted, out_valid[i] and out_data[i] stay stable until the handshake completes.

Optional Feature:
- Macro: DEMUX8_BCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - When in_bcast=1, in_ready = &ch_free and in_sel is ignored.
  - On acc, all eight channels load in_data and all out_valid bits are set at the same edge.
  - xfer_cnt increments by 1.
  - When in_bcast=0, behaviour is unicast as above.
- Not defined: the in_bcast port does not exist and the block is unicast only.

Test Plan:
- Reset then single write: rst 2 cycles; in_sel=3, in_data=0xDEADBEEF, in_valid=1 for 1 cycle; out_ready=0 -> out_valid=8'h08 next cycle, channel 3 data=0xDEADBEEF, xfer_cnt=1, all other channels unchanged.
- Backpressure: with channel 3 full and out_ready[3]=0, drive in_sel=3, in_data=0x12345678 -> in_ready=0 and channel 3 keeps 0xDEADBEEF. Then drive in_sel=5 -> in_ready=1 and channel 5 loads 0x12345678 next cycle.
- Drain and refill same cycle: channel 2 holds 0xA; out_ready[2]=1 with in_sel=2, in_data=0xB accepted -> out_valid[2] stays 1, channel 2 data=0xB next cycle, xfer_cnt +1.
- Full sweep: write 0x100+i to each channel i=0..7 on 8 back-to-back cycles with out_ready=0 -> out_valid=8'hFF, each channel i holds 0x100+i. Then out_ready=8'hFF for one cycle -> out_valid=8'h00.
- Counter wrap and reset: preload xfer_cnt to 0xFFFF via 65535 accepts, one more accept -> xfer_cnt=0x0000. Assert rst while out_valid=8'hFF and in_valid=1 -> out_valid=0 and xfer_cnt=0 next cycle, input word not counted.
- DEMUX8_BCAST_EN: in_bcast=1, in_data=0x55AA55AA with all channels free -> out_valid=8'hFF and all channels=0x55AA55AA, xfer_cnt +1. Repeat with channel 6 full and out_ready[6]=0 -> in_ready=0 and no channel changes.
